// File: rtl/usb_ft1248_device.sv
// FT1248 device-side responder: decodes the command byte, returns ACK/NAK on ft_miso and moves
// bytes between the oversampled bus and show-ahead FIFOs. All bus inputs are synchronized to clk.
module usb_ft1248_device #(
  parameter int          SYNC_STAGES        = 2,
  parameter logic [7:0]  MODEM_STATUS_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ft_clk,
  input  logic       ft_cs,
  output logic       ft_miso,
  input  logic [7:0] ft_miosi_in,
  output logic [7:0] ft_miosi_out,
  output logic       ft_miosi_oe,
  input  logic       rx_full,
  output logic       rx_write,
  output logic [7:0] rx_wdata,
  input  logic       tx_empty,
  output logic       tx_read,
  input  logic [7:0] tx_rdata,
  input  logic [7:0] modem_status_in,
  output logic [7:0] modem_status_out,
  output logic       modem_status_wr,
  output logic       flush_req,
  output logic       busy
);

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h40;
  localparam logic [7:0] CMD_MSR   = 8'h20;
  localparam logic [7:0] CMD_MSW   = 8'h60;
  localparam logic [7:0] CMD_FLUSH = 8'h08;

  typedef enum logic [2:0] {
    IDLE, COMMAND, STATUS, DATA, WAIT_DESELECT
  } state_t;

  logic [SYNC_STAGES-1:0]      clk_sync_q;
  logic [SYNC_STAGES-1:0]      cs_sync_q;
  logic [SYNC_STAGES-1:0][7:0] din_sync_q;
  logic                        clk_prev_q;
  logic                        cs_prev_q;

  state_t     state_q;
  logic [7:0] cmd_q;
  logic       miso_q;
  logic [7:0] dout_q;
  logic       oe_q;
  logic       rx_write_q;
  logic [7:0] rx_wdata_q;
  logic       tx_read_q;
  logic [7:0] ms_out_q;
  logic       ms_wr_q;
  logic       flush_q;
  logic       busy_q;

  logic       clk_s, cs_s;
  logic [7:0] din_s;
  logic       clk_rise, clk_fall, cs_fall;
  logic       status_ack;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  // cs synchronizer resets to "selected" so a held-low ft_cs after reset is not taken as a new fall
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '0;
      cs_sync_q  <= '0;
      din_sync_q <= '0;
      clk_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ft_clk};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], ft_cs};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], ft_miosi_in};
      clk_prev_q <= clk_s;
      cs_prev_q  <= cs_s;
    end
  end

  always_comb begin
    status_ack = 1'b0;
    case (cmd_q)
      CMD_READ:                   status_ack = ~tx_empty;
      CMD_WRITE:                  status_ack = ~rx_full;
      CMD_MSR, CMD_MSW, CMD_FLUSH: status_ack = 1'b1;
      default:                    status_ack = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      miso_q     <= 1'b1;
      dout_q     <= 8'hFF;
      oe_q       <= 1'b0;
      rx_write_q <= 1'b0;
      rx_wdata_q <= 8'h00;
      tx_read_q  <= 1'b0;
      ms_out_q   <= MODEM_STATUS_RESET;
      ms_wr_q    <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_write_q <= 1'b0;
      tx_read_q  <= 1'b0;
      ms_wr_q    <= 1'b0;
      flush_q    <= 1'b0;
      if (state_q != IDLE && cs_s) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        miso_q  <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q <= COMMAND;
              busy_q  <= 1'b1;
            end
          end
          COMMAND: begin
            if (clk_fall) begin
              cmd_q   <= din_s;
              state_q <= STATUS;
            end
          end
          STATUS: begin
            // miso_q doubles as the "this bit cycle was ACKed" flag for the following fall
            if (clk_rise)      miso_q  <= ~status_ack;
            else if (clk_fall) state_q <= miso_q ? WAIT_DESELECT : DATA;
          end
          DATA: begin
            case (cmd_q)
              CMD_READ: begin
                if (clk_rise) begin
                  if (!tx_empty) begin
                    dout_q    <= tx_rdata;
                    oe_q      <= 1'b1;
                    miso_q    <= 1'b0;
                    tx_read_q <= 1'b1;
                  end else begin
                    miso_q  <= 1'b1;
                    oe_q    <= 1'b0;
                    state_q <= WAIT_DESELECT;
                  end
                end
              end
              CMD_WRITE: begin
                if (clk_rise) begin
                  miso_q <= rx_full;
                end else if (clk_fall) begin
                  if (!miso_q) begin
                    rx_wdata_q <= din_s;
                    rx_write_q <= 1'b1;
                  end else begin
                    state_q <= WAIT_DESELECT;
                  end
                end
              end
              CMD_MSR: begin
                if (clk_rise) begin
                  dout_q <= modem_status_in;
                  oe_q   <= 1'b1;
                  miso_q <= 1'b0;
                end else if (clk_fall) begin
                  state_q <= WAIT_DESELECT;
                end
              end
              CMD_MSW: begin
                if (clk_rise) begin
                  miso_q <= 1'b0;
                end else if (clk_fall) begin
                  ms_out_q <= din_s;
                  ms_wr_q  <= 1'b1;
                  state_q  <= WAIT_DESELECT;
                end
              end
              CMD_FLUSH: begin
                if (clk_rise) begin
                  miso_q <= 1'b0;
                end else if (clk_fall) begin
                  flush_q <= 1'b1;
                  state_q <= WAIT_DESELECT;
                end
              end
              default: state_q <= WAIT_DESELECT;
            endcase
          end
          WAIT_DESELECT: begin
            if (clk_rise) begin
              miso_q <= 1'b1;
              oe_q   <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ft_miso          = miso_q;
  assign ft_miosi_out     = dout_q;
  assign ft_miosi_oe      = oe_q;
  assign rx_write         = rx_write_q;
  assign rx_wdata         = rx_wdata_q;
  assign tx_read          = tx_read_q;
  assign modem_status_out = ms_out_q;
  assign modem_status_wr  = ms_wr_q;
  assign flush_req        = flush_q;
  assign busy             = busy_q;

endmodule
